// File: rtl/rom_msg_streamer_pkg.sv
// Shared definitions for the message ROM streamers.
// Holds the streamer FSM state encoding, the default ROM geometry and the
// lengths of the per-player winner messages so both paths use one streamer.
package rom_msg_streamer_pkg;

  localparam int unsigned ADDR_W_DEF    = 4;
  localparam int unsigned DATA_W_DEF    = 8;

  // "P1 WINS!" and "P2 WINS!"
  localparam int unsigned MSG_LEN_P1WIN = 8;
  localparam int unsigned MSG_LEN_P2WIN = 8;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StSend,
    StDone
  } state_e;

endpackage

// File: rtl/rom_msg_streamer.sv
// Walks an external synchronous message ROM from address 0 to MSG_LEN-1 and
// presents each byte on a valid/ready stream.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   start     request to stream the message (only honoured when idle)
//   rom_addr  address to the external 1-cycle-latency ROM
//   rom_data  registered ROM output
//   tx_data   stream byte
//   tx_valid  tx_data is valid
//   tx_ready  downstream accepts the byte
//   busy      high whenever not idle
//   done      one-cycle pulse at end of message (last byte accepted or NUL)
module rom_msg_streamer
  import rom_msg_streamer_pkg::*;
#(
  parameter int unsigned MSG_LEN     = MSG_LEN_P2WIN,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter bit          STOP_ON_NUL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(MSG_LEN - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                done_q, done_d;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          index_d = '0;
        end
      end
      // ROM samples rom_addr on this edge; its data is usable one edge later.
      StFetch: state_d = StWait;
      StWait: begin
        tx_data_d = rom_data;
        if (STOP_ON_NUL && (rom_data == '0)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          tx_valid_d = 1'b1;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          // Compare before increment so the index never wraps past all-ones.
          if (index_q == LastIdx) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      index_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  // The ROM address is the message index; it is only changed on a transfer,
  // so it stays stable across FETCH and WAIT.
  assign rom_addr = index_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign done     = done_q;
  assign busy     = (state_q != StIdle);

endmodule
